// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute stage.
// Contents:
//   - alu_op classes driven by main control.
//   - R-type funct field encodings.
//   - 4-bit ALU control codes produced by alu_ctl_decode and consumed by alu_exec_unit.
package alu_pkg;

  // Operation class from main control
  localparam logic [1:0] AluOpAdd   = 2'b00;  // loads/stores: address add
  localparam logic [1:0] AluOpSub   = 2'b01;  // branches: compare by subtract
  localparam logic [1:0] AluOpRtype = 2'b10;  // decode from funct
  localparam logic [1:0] AluOpAddI  = 2'b11;  // immediate add

  // R-type funct encodings (instruction bits [5:0])
  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;
  localparam logic [5:0] FunctNor = 6'b100111;

  // ALU control codes
  localparam logic [3:0] AluCtlAnd     = 4'b0000;
  localparam logic [3:0] AluCtlOr      = 4'b0001;
  localparam logic [3:0] AluCtlAdd     = 4'b0010;
  localparam logic [3:0] AluCtlSub     = 4'b0110;
  localparam logic [3:0] AluCtlSlt     = 4'b0111;
  localparam logic [3:0] AluCtlNor     = 4'b1100;
  localparam logic [3:0] AluCtlInvalid = 4'b1111;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALU control decoder.
// Maps the main-control operation class and the R-type funct field to a 4-bit ALU control code.
// Ports:
//   alu_op_i   [1:0]  operation class
//   funct_i    [5:0]  instruction bits [5:0], only used when alu_op_i is R-type
//   alu_ctl_o  [3:0]  decoded ALU control code; unknown funct decodes to INVALID
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o
);

  always_comb begin
    alu_ctl_o = AluCtlInvalid;
    unique case (alu_op_i)
      AluOpAdd:  alu_ctl_o = AluCtlAdd;
      AluOpSub:  alu_ctl_o = AluCtlSub;
      AluOpAddI: alu_ctl_o = AluCtlAdd;
      AluOpRtype: begin
        case (funct_i)
          FunctAdd: alu_ctl_o = AluCtlAdd;
          FunctSub: alu_ctl_o = AluCtlSub;
          FunctAnd: alu_ctl_o = AluCtlAnd;
          FunctOr:  alu_ctl_o = AluCtlOr;
          FunctSlt: alu_ctl_o = AluCtlSlt;
          FunctNor: alu_ctl_o = AluCtlNor;
          default:  alu_ctl_o = AluCtlInvalid;
        endcase
      end
      default: alu_ctl_o = AluCtlInvalid;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage with registered outputs (one cycle latency).
// The stage decodes the control code, computes the ALU result, detects a zero result and
// resolves the branch-taken flag.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset; clears all outputs immediately
//   alu_op   [1:0]        operation class from main control
//   funct    [5:0]        instruction bits [5:0]
//   a        [WIDTH-1:0]  operand A
//   b        [WIDTH-1:0]  operand B
//   branch                branch flag from main control
//   alu_ctl  [3:0]        registered control code
//   result   [WIDTH-1:0]  registered ALU result
//   zero                  registered result == 0 flag
//   pc_src                registered branch-taken flag
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             branch,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             pc_src
);

  logic [3:0]       alu_ctl_d, alu_ctl_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             pc_src_d, pc_src_q;
  logic             slt_lt;

  alu_ctl_decode u_alu_ctl_decode (
    .alu_op_i  (alu_op),
    .funct_i   (funct),
    .alu_ctl_o (alu_ctl_d)
  );

  assign slt_lt = $signed(a) < $signed(b);

  // ADD/SUB wrap modulo 2^WIDTH; no overflow indication.
  always_comb begin
    result_d = '0;
    case (alu_ctl_d)
      AluCtlAnd: result_d = a & b;
      AluCtlOr:  result_d = a | b;
      AluCtlAdd: result_d = a + b;
      AluCtlSub: result_d = a - b;
      AluCtlSlt: result_d = {{(WIDTH-1){1'b0}}, slt_lt};
      AluCtlNor: result_d = ~(a | b);
      default:   result_d = '0;
    endcase
  end

  assign zero_d   = (result_d == '0);
  assign pc_src_d = branch & zero_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_ctl_q <= 4'b0000;
      result_q  <= '0;
      zero_q    <= 1'b0;
      pc_src_q  <= 1'b0;
    end else begin
      alu_ctl_q <= alu_ctl_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      pc_src_q  <= pc_src_d;
    end
  end

  assign alu_ctl = alu_ctl_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign pc_src  = pc_src_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH = 32).
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        branch;
  logic [3:0]  alu_ctl;
  logic [31:0] result;
  logic        zero;
  logic        pc_src;

  int n_tests;
  int n_fail;

  alu_exec_unit #(
    .WIDTH (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_op  (alu_op),
    .funct   (funct),
    .a       (a),
    .b       (b),
    .branch  (branch),
    .alu_ctl (alu_ctl),
    .result  (result),
    .zero    (zero),
    .pc_src  (pc_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, let one rising edge capture them, then settle 1 ns past the edge.
  task automatic apply(input logic [1:0] op, input logic [5:0] f, input logic [31:0] aa,
                       input logic [31:0] bb, input logic br);
    alu_op = op;
    funct  = f;
    a      = aa;
    b      = bb;
    branch = br;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_op = 2'(i);
      funct  = 6'b100000;
      a      = 32'h1111_0000 + 32'(i);
      b      = 32'h0000_0003;
      branch = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (alu_ctl !== 4'b0000 || result !== 32'h0 || zero !== 1'b0 || pc_src !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: ctl=%b res=%h z=%b pc=%b, want all 0",
                 i, alu_ctl, result, zero, pc_src);
      end
    end
    alu_op = 2'b00;
    funct  = 6'b000000;
    a      = 32'd5;
    b      = 32'd7;
    branch = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (result !== 32'd12 || alu_ctl !== 4'b0010 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ctl=%b res=%h z=%b, want ctl=0010 res=0000000c z=0",
               alu_ctl, result, zero);
    end
  endtask

  task automatic test_hold();
    // Inputs change mid-cycle; outputs must keep the last captured value.
    a = 32'd100;
    b = 32'd1;
    alu_op = 2'b01;
    #3;
    n_tests++;
    if (result !== 32'd12 || alu_ctl !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold: ctl=%b res=%h, want ctl=0010 res=0000000c", alu_ctl, result);
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  f_tab   [6];
    logic [3:0]  ctl_tab [6];
    logic [31:0] res_tab [6];
    f_tab   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    ctl_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
    res_tab = '{32'h16, 32'h2, 32'h8, 32'hE, 32'h0, 32'hFFFF_FFF1};
    for (int i = 0; i < 6; i++) begin
      apply(2'b10, f_tab[i], 32'h0000_000C, 32'h0000_000A, 1'b0);
      n_tests++;
      if (alu_ctl !== ctl_tab[i] || result !== res_tab[i] ||
          zero !== (res_tab[i] == 32'h0)) begin
        n_fail++;
        $display("FAIL rtype[%0d]: ctl=%b res=%h z=%b, want ctl=%b res=%h",
                 i, alu_ctl, result, zero, ctl_tab[i], res_tab[i]);
      end
    end
    // alu_op 11 is an add regardless of funct
    apply(2'b11, 6'b100010, 32'd40, 32'd2, 1'b0);
    n_tests++;
    if (alu_ctl !== 4'b0010 || result !== 32'd42) begin
      n_fail++;
      $display("FAIL addi: ctl=%b res=%h, want ctl=0010 res=0000002a", alu_ctl, result);
    end
  endtask

  task automatic test_branch();
    apply(2'b01, 6'b000000, 32'h1234, 32'h1234, 1'b1);
    n_tests++;
    if (alu_ctl !== 4'b0110 || result !== 32'h0 || zero !== 1'b1 || pc_src !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_taken: ctl=%b res=%h z=%b pc=%b, want 0110 00000000 1 1",
               alu_ctl, result, zero, pc_src);
    end
    apply(2'b01, 6'b000000, 32'h1234, 32'h1235, 1'b1);
    n_tests++;
    if (result !== 32'hFFFF_FFFF || zero !== 1'b0 || pc_src !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_not_taken: res=%h z=%b pc=%b, want ffffffff 0 0",
               result, zero, pc_src);
    end
    apply(2'b01, 6'b000000, 32'h55, 32'h55, 1'b0);
    n_tests++;
    if (zero !== 1'b1 || pc_src !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_off: z=%b pc=%b, want 1 0", zero, pc_src);
    end
  endtask

  task automatic test_wrap_sign();
    apply(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'h1, 1'b0);
    n_tests++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap: res=%h z=%b, want 00000000 1", result, zero);
    end
    apply(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h0, 1'b0);
    n_tests++;
    if (result !== 32'h1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL slt_neg: res=%h z=%b, want 00000001 0", result, zero);
    end
    apply(2'b10, 6'b101010, 32'h8000_0000, 32'h1, 1'b0);
    n_tests++;
    if (result !== 32'h1) begin
      n_fail++;
      $display("FAIL slt_min: res=%h, want 00000001", result);
    end
    apply(2'b10, 6'b101010, 32'h1, 32'h8000_0000, 1'b0);
    n_tests++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL slt_rev: res=%h z=%b, want 00000000 1", result, zero);
    end
    apply(2'b01, 6'b000000, 32'h0, 32'h1, 1'b0);
    n_tests++;
    if (result !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sub_wrap: res=%h, want ffffffff", result);
    end
  endtask

  task automatic test_invalid();
    apply(2'b10, 6'b111111, 32'h0000_000C, 32'h0000_000A, 1'b0);
    n_tests++;
    if (alu_ctl !== 4'b1111 || result !== 32'h0 || zero !== 1'b1 || pc_src !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid: ctl=%b res=%h z=%b pc=%b, want 1111 00000000 1 0",
               alu_ctl, result, zero, pc_src);
    end
    apply(2'b10, 6'b000000, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    n_tests++;
    if (alu_ctl !== 4'b1111 || result !== 32'h0 || pc_src !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_branch: ctl=%b res=%h pc=%b, want 1111 00000000 1",
               alu_ctl, result, pc_src);
    end
  endtask

  task automatic test_async_reset();
    apply(2'b10, 6'b100000, 32'h0000_000C, 32'h0000_000A, 1'b0);
    n_tests++;
    if (result !== 32'h16) begin
      n_fail++;
      $display("FAIL async_pre: res=%h, want 00000016", result);
    end
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (alu_ctl !== 4'b0000 || result !== 32'h0 || zero !== 1'b0 || pc_src !== 1'b0) begin
      n_fail++;
      $display("FAIL async_drop: ctl=%b res=%h z=%b pc=%b, want all 0",
               alu_ctl, result, zero, pc_src);
    end
    // Release between edges: nothing pending may reappear before the next edge.
    rst = 1'b1;
    #1;
    n_tests++;
    if (result !== 32'h0 || alu_ctl !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_release: ctl=%b res=%h, want 0000 00000000", alu_ctl, result);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (result !== 32'h16 || alu_ctl !== 4'b0010) begin
      n_fail++;
      $display("FAIL async_recapture: ctl=%b res=%h, want 0010 00000016", alu_ctl, result);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    alu_op  = 2'b00;
    funct   = 6'b000000;
    a       = 32'h0;
    b       = 32'h0;
    branch  = 1'b0;
    #1;
    test_reset();
    test_hold();
    test_rtype();
    test_branch();
    test_wrap_sign();
    test_invalid();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have the following ports, clock and reset first:
- clk      input   1      rising-edge clock
- rst      input   1      asynchronous active-low reset
- alu_op   input   2      operation class from main control
- funct    input   6      instruction bits [5:0]
- a        input   WIDTH  operand A (register read data 1)
- b        input   WIDTH  operand B (register data 2 or sign-extended immediate)
- branch   input   1      branch flag from main control
- alu_ctl  output  4      registered decoded ALU control code
- result   output  WIDTH  registered ALU result
- zero     output  1      registered flag: ALU result equals 0
- pc_src   output  1      registered branch-taken flag

Function
REQ-004 The block SHALL decode alu_op and funct combinationally into a 4-bit control code as follows:
- alu_op 00: ADD 0010
- alu_op 01: SUB 0110
- alu_op 11: ADD 0010
- alu_op 10: decode funct:
  - 100000: ADD 0010
  - 100010: SUB 0110
  - 100100: AND 0000
  - 100101: OR 0001
  - 101010: SLT 0111
  - 100111: NOR 1100
  - any other funct: INVALID 1111
REQ-005 For each control code, the ALU SHALL compute the following:
- AND: a&b
- OR: a|b
- ADD: a+b modulo 2^WIDTH, carry discarded
- SUB: a-b modulo 2^WIDTH
- SLT: 1 when signed a < signed b, else 0, zero-extended to WIDTH
- NOR: ~(a|b)
- 1111 and any other code: result 0
REQ-006 The unregistered zero flag SHALL be 1 exactly when the computed ALU result equals 0, for every operation including INVALID.
REQ-007 The unregistered pc_src SHALL be branch AND the unregistered zero flag.
REQ-008 On each rising clk edge with rst high, the block SHALL capture the control code, result, zero and pc_src into the output registers together, giving 1-cycle latency from inputs to outputs.
REQ-009 Outputs SHALL be held stable between clock edges; input changes between edges SHALL NOT affect the outputs.
REQ-010 Overflow on ADD and SUB SHALL wrap silently; no overflow flag or exception is produced.
REQ-011 SLT SHALL compare the inputs as two's-complement numbers, e.g. a=0x80000000 and b=0x00000001 gives result 1.

Reset
REQ-012 Asserting rst low SHALL immediately, without waiting for clk, force all outputs to 0: alu_ctl=0000, result=0, zero=0, pc_src=0.
REQ-013 While rst is low, outputs SHALL stay at their reset values.
REQ-014 The first rising edge after rst goes high SHALL capture the current inputs normally.
REQ-015 A reset asserted mid-operation SHALL discard the pending result; no partial state survives.

Structure
REQ-016 The ALU control code constants (AND, OR, ADD, SUB, SLT, NOR, INVALID), the funct constants and the alu_op constants SHALL be defined in a shared package, alu_pkg.
REQ-017 The funct/alu_op decoder SHALL be one sub-module, alu_ctl_decode, which is purely combinational.
REQ-018 The arithmetic, zero detection, branch AND and output registers SHALL reside in the top level.

Verification
REQ-019 Reset: hold rst low and toggle inputs -> all outputs 0. Release rst with alu_op=00, a=5, b=7 -> after one edge, result=12, alu_ctl=0010, zero=0.
REQ-020 R-type sweep: alu_op=10 with a=0x0000000C, b=0x0000000A -> results per funct:
- ADD: 0x16
- SUB: 0x2
- AND: 0x8
- OR: 0xE
- SLT: 0
- NOR: 0xFFFFFFF1
REQ-021 Branch: branch=1, alu_op=01, a=b=0x1234 -> result=0, zero=1, pc_src=1. With a=0x1234, b=0x1235 -> result=0xFFFFFFFF, pc_src=0.
REQ-022 Wrap and sign: ADD with a=0xFFFFFFFF, b=1 -> result=0, zero=1. SLT with a=0xFFFFFFFF (-1), b=0 -> result=1.
REQ-023 Invalid funct: alu_op=10, funct=111111 -> alu_ctl=1111, result=0, zero=1. With branch=0 -> pc_src=0.
REQ-024 Async reset: assert rst low between clock edges while result=0x16 -> outputs drop to 0 before the next edge.
